imem_arbiter: RTL and testbench

- Sequences the single-port instruction memory and shares it between two requesters: the core fetch unit (reads) and the program loader (writes).
- The memory has one read/write select: `fetch_en`=1 registers the read word; `fetch_en`=0 writes the bidirectional data bus into memory[pc] on every clock.
- This block owns `fetch_en`, `pc` and the write-side drive of the data bus, so no stray write can ever occur.
- Sits between core/loader and the instruction memory.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_arbiter_if.sv | 48 ++++
 rtl/imem_arbiter.sv | 130 +++++++++++++
 tb/tb_imem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory arbiter.
package imem_pkg;

    localparam int IMEM_AW = 8;
    localparam int IMEM_DW = 32;

    // Word the instruction memory holds after power-up.
    localparam logic [IMEM_DW-1:0] IMEM_NOP = 32'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2,
        WR   = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the core fetch port, the loader write port and the memory port.
// slave: the arbiter's view. master: the surrounding core/loader/memory.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
);
    // core fetch side
    logic          core_req_valid;
    logic          core_req_ready;
    logic [AW-1:0] core_pc;
    logic          core_flush;
    logic          core_rsp_valid;
    logic [DW-1:0] core_instr;
    // loader side
    logic          ld_req_valid;
    logic          ld_req_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
    logic [AW:0]   ld_count;
    // memory side
    logic          mem_fetch_en;
    logic [AW-1:0] mem_pc;
    logic [DW-1:0] mem_wdata;
    logic          mem_wdata_oe;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req_valid, core_pc, core_flush,
        input  ld_req_valid, ld_addr, ld_data,
        input  mem_rdata,
        output core_req_ready, core_rsp_valid, core_instr,
        output ld_req_ready, ld_ack, ld_count,
        output mem_fetch_en, mem_pc, mem_wdata, mem_wdata_oe
    );

    modport master (
        output core_req_valid, core_pc, core_flush,
        output ld_req_valid, ld_addr, ld_data,
        output mem_rdata,
        input  core_req_ready, core_rsp_valid, core_instr,
        input  ld_req_ready, ld_ack, ld_count,
        input  mem_fetch_en, mem_pc, mem_wdata, mem_wdata_oe
    );

endinterface

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction memory between the core fetch unit
// (reads) and the program loader (writes). The arbiter is the only owner of
// the memory's fetch_en/pc and of the write drive, so the memory only ever
// writes during the one WR cycle of an accepted loader request.
// Optional build macro IMEM_ARB_RR_EN: round-robin between simultaneous
// requesters instead of fixed loader-first priority.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RD   = RD;
    localparam logic [1:0] S_RSP  = RSP;
    localparam logic [1:0] S_WR   = WR;

    localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          flush_q;
    logic          ld_ack_q;
    logic [AW:0]   count_q;
    logic          ld_grant, core_grant;
    logic          rsp_fire;
    logic          in_wr;

`ifdef IMEM_ARB_RR_EN
    logic          last_grant_ld_q;
`endif

    // Grant arbitration: only in IDLE and never while reset is asserted.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ld_grant   = 1'b0;
        core_grant = 1'b0;
        if (rst_n && state_q == S_IDLE) begin
`ifdef IMEM_ARB_RR_EN
            if (bus.ld_req_valid && bus.core_req_valid) begin
                ld_grant   = !last_grant_ld_q;
                core_grant = last_grant_ld_q;
            end else begin
                ld_grant   = bus.ld_req_valid;
                core_grant = bus.core_req_valid;
            end
`else
            ld_grant   = bus.ld_req_valid;
            core_grant = bus.core_req_valid && !bus.ld_req_valid;
`endif
        end
    end

    // Next-state logic: IDLE is revisited between every pair of transactions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ld_grant)        state_d = S_WR;
                else if (core_grant) state_d = S_RD;
            end
            S_RD:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, request capture, flush tracking, write acknowledge and counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            flush_q  <= 1'b0;
            ld_ack_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ld_ack_q <= (state_q == S_WR);
            if (ld_grant) begin
                addr_q <= bus.ld_addr;
                data_q <= bus.ld_data;
            end else if (core_grant) begin
                addr_q <= bus.core_pc;
            end
            if (state_q == S_RSP)
                flush_q <= 1'b0;
            else if (bus.core_flush && (core_grant || state_q == S_RD))
                flush_q <= 1'b1;
            if (state_q == S_WR && count_q != COUNT_MAX)
                count_q <= count_q + (AW+1)'(1);
        end
    end

`ifdef IMEM_ARB_RR_EN
    // Remember who won the last contested grant; reset favours the loader.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant_ld_q <= 1'b0;
        else if (bus.ld_req_valid && bus.core_req_valid && (ld_grant || core_grant))
            last_grant_ld_q <= ld_grant;
    end
`endif

    // A flush raised in the response cycle itself also cancels that response.
    assign rsp_fire = (state_q == S_RSP) && !flush_q && !bus.core_flush;
    assign in_wr    = (state_q == S_WR);

    assign bus.core_req_ready = core_grant;
    assign bus.ld_req_ready   = ld_grant;
    assign bus.core_rsp_valid = rsp_fire;
    assign bus.core_instr     = rsp_fire ? bus.mem_rdata : '0;
    assign bus.ld_ack         = ld_ack_q;
    assign bus.ld_count       = count_q;

    // The memory writes whenever fetch_en is low, so it is low only in WR.
    assign bus.mem_fetch_en   = !in_wr;
    assign bus.mem_wdata_oe   = in_wr;
    assign bus.mem_pc         = addr_q;
    assign bus.mem_wdata      = in_wr ? data_q : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: models the single-port memory and its shared data
// bus, then applies directed transactions with hand-computed expectations.
module tb_imem_arbiter;
    import imem_pkg::*;

    logic clk;
    logic rst_n;

    imem_arbiter_if #(.AW(8), .DW(32)) bus ();

    imem_arbiter #(.AW(8), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: the data bus carries the arbiter's drive when enabled,
    // otherwise the memory's registered read word.
    logic [31:0] mem [256] = '{default: IMEM_NOP};
    logic [31:0] mem_rdata_q = '0;
    logic [31:0] data_bus;
    int          n_writes = 0;

    assign data_bus      = bus.mem_wdata_oe ? bus.mem_wdata : mem_rdata_q;
    assign bus.mem_rdata = data_bus;

    always @(posedge clk) begin
        if (bus.mem_fetch_en) begin
            mem_rdata_q <= mem[bus.mem_pc];
        end else begin
            mem[bus.mem_pc] <= data_bus;
            n_writes        <= n_writes + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // fetch_en low and write-enable high must always coincide.
    always @(negedge clk) begin
        if (mon_en)
            check("fetch_en_vs_oe", 64'(bus.mem_fetch_en), 64'(!bus.mem_wdata_oe));
    end

    task automatic wait_ready(input bit is_ld);
        bit ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (is_ld ? bus.ld_req_ready : bus.core_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(is_ld ? "ld_grant_timeout" : "core_grant_timeout", 64'(ok), 64'(1));
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ld_req_valid = 1'b1;
        bus.ld_addr      = a;
        bus.ld_data      = d;
        wait_ready(1'b1);
        @(negedge clk);                         // WR cycle
        bus.ld_req_valid = 1'b0;
        check("wr_oe",       64'(bus.mem_wdata_oe), 64'(1));
        check("wr_fetch_en", 64'(bus.mem_fetch_en), 64'(0));
        check("wr_pc",       64'(bus.mem_pc),       64'(a));
        check("wr_wdata",    64'(bus.mem_wdata),    64'(d));
        check("wr_ack_early",64'(bus.ld_ack),       64'(0));
        @(negedge clk);                         // ack cycle, back in IDLE
        check("wr_ack",      64'(bus.ld_ack),       64'(1));
        check("wr_oe_drop",  64'(bus.mem_wdata_oe), 64'(0));
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp_i);
        @(negedge clk);
        bus.core_req_valid = 1'b1;
        bus.core_pc        = a;
        wait_ready(1'b0);
        @(negedge clk);                         // RD cycle
        bus.core_req_valid = 1'b0;
        check("rd_rsp_early", 64'(bus.core_rsp_valid), 64'(0));
        check("rd_pc",        64'(bus.mem_pc),         64'(a));
        @(negedge clk);                         // RSP cycle
        check("rd_rsp",       64'(bus.core_rsp_valid), 64'(1));
        check("rd_instr",     64'(bus.core_instr),     64'(exp_i));
        @(negedge clk);                         // IDLE: pulse is over
        check("rd_rsp_pulse", 64'(bus.core_rsp_valid), 64'(0));
    endtask

    task automatic simult(input logic [7:0] la, input logic [31:0] ldat,
                          input logic [7:0] cpc, input logic [31:0] exp_i,
                          input bit ld_first);
        @(negedge clk);
        bus.ld_req_valid   = 1'b1;
        bus.ld_addr        = la;
        bus.ld_data        = ldat;
        bus.core_req_valid = 1'b1;
        bus.core_pc        = cpc;
        #1;
        check("sim_ld_ready",   64'(bus.ld_req_ready),   64'(ld_first));
        check("sim_core_ready", 64'(bus.core_req_ready), 64'(!ld_first));
        if (ld_first) begin
            @(negedge clk);                     // WR, core still pending
            bus.ld_req_valid = 1'b0;
            #1;
            check("sim_wr_oe",     64'(bus.mem_wdata_oe),   64'(1));
            check("sim_core_held", 64'(bus.core_req_ready), 64'(0));
            @(negedge clk);                     // IDLE: ack and core grant
            #1;
            check("sim_ack",        64'(bus.ld_ack),         64'(1));
            check("sim_core_grant", 64'(bus.core_req_ready), 64'(1));
            @(negedge clk);                     // RD
            bus.core_req_valid = 1'b0;
            @(negedge clk);                     // RSP
            check("sim_rsp",   64'(bus.core_rsp_valid), 64'(1));
            check("sim_instr", 64'(bus.core_instr),     64'(exp_i));
        end else begin
            @(negedge clk);                     // RD, loader still pending
            bus.core_req_valid = 1'b0;
            #1;
            check("sim_ld_held", 64'(bus.ld_req_ready), 64'(0));
            @(negedge clk);                     // RSP
            check("sim_rsp",   64'(bus.core_rsp_valid), 64'(1));
            check("sim_instr", 64'(bus.core_instr),     64'(exp_i));
            @(negedge clk);                     // IDLE: loader granted
            #1;
            check("sim_ld_grant", 64'(bus.ld_req_ready), 64'(1));
            @(negedge clk);                     // WR
            bus.ld_req_valid = 1'b0;
            check("sim_wr_wdata", 64'(bus.mem_wdata), 64'(ldat));
            @(negedge clk);
            check("sim_ack", 64'(bus.ld_ack), 64'(1));
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;       // write data, or expected fetched word
        logic [8:0]  exp_count;  // ld_count after the transaction
    } vec_t;

    vec_t vecs [8];
    int   wr_before;

    initial begin
        vecs[0] = '{1'b0, 8'h10, 32'h0000_000F, 9'd0};
        vecs[1] = '{1'b1, 8'h05, 32'hDEAD_BEEF, 9'd1};
        vecs[2] = '{1'b0, 8'h05, 32'hDEAD_BEEF, 9'd1};
        vecs[3] = '{1'b1, 8'hFF, 32'hA5A5_0001, 9'd2};
        vecs[4] = '{1'b1, 8'h00, 32'h0000_0042, 9'd3};
        vecs[5] = '{1'b0, 8'hFF, 32'hA5A5_0001, 9'd3};
        vecs[6] = '{1'b0, 8'h00, 32'h0000_0042, 9'd3};
        vecs[7] = '{1'b0, 8'h06, 32'h0000_000F, 9'd3};

        rst_n              = 1'b0;
        bus.core_req_valid = 1'b1;
        bus.core_pc        = '0;
        bus.core_flush     = 1'b0;
        bus.ld_req_valid   = 1'b1;
        bus.ld_addr        = '0;
        bus.ld_data        = '0;

        // Reset: requests present but never granted.
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        #1;
        check("rst_ld_ready",   64'(bus.ld_req_ready),   64'(0));
        check("rst_core_ready", 64'(bus.core_req_ready), 64'(0));
        check("rst_pc",         64'(bus.mem_pc),         64'(0));
        check("rst_wdata",      64'(bus.mem_wdata),      64'(0));
        check("rst_count",      64'(bus.ld_count),       64'(0));
        check("rst_instr",      64'(bus.core_instr),     64'(0));
        bus.core_req_valid = 1'b0;
        bus.ld_req_valid   = 1'b0;
        rst_n              = 1'b1;

        // Idle for 10 cycles: only harmless reads.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_fetch_en", 64'(bus.mem_fetch_en),   64'(1));
            check("idle_oe",       64'(bus.mem_wdata_oe),   64'(0));
            check("idle_ack",      64'(bus.ld_ack),         64'(0));
            check("idle_rsp",      64'(bus.core_rsp_valid), 64'(0));
        end

        // Directed transaction table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
            else               do_read(vecs[i].addr, vecs[i].data);
            check("vec_count", 64'(bus.ld_count), 64'(vecs[i].exp_count));
        end

        // Simultaneous requests.
        simult(8'h07, 32'h1234_5678, 8'h07, 32'h1234_5678, 1'b1);
        check("sim1_count", 64'(bus.ld_count), 64'(4));
`ifdef IMEM_ARB_RR_EN
        simult(8'h08, 32'hCAFE_F00D, 8'h07, 32'h1234_5678, 1'b0);
`else
        simult(8'h08, 32'hCAFE_F00D, 8'h07, 32'h1234_5678, 1'b1);
`endif
        check("sim2_count", 64'(bus.ld_count), 64'(5));
        do_read(8'h08, 32'hCAFE_F00D);

        // Flush while the fetch is in RD: response suppressed, no write.
        wr_before = n_writes;
        @(negedge clk);
        bus.core_req_valid = 1'b1;
        bus.core_pc        = 8'h20;
        wait_ready(1'b0);
        @(negedge clk);                         // RD
        bus.core_req_valid = 1'b0;
        bus.core_flush     = 1'b1;
        check("flush_rd_rsp", 64'(bus.core_rsp_valid), 64'(0));
        @(negedge clk);                         // RSP with flush pending
        bus.core_flush     = 1'b0;
        #1;
        check("flush_rsp", 64'(bus.core_rsp_valid), 64'(0));
        @(negedge clk);
        check("flush_after", 64'(bus.core_rsp_valid), 64'(0));
        do_read(8'hFF, 32'hA5A5_0001);
        check("flush_no_write", 64'(n_writes - wr_before), 64'(0));

        // Reset asserted during WR: transaction abandoned.
        @(negedge clk);
        bus.ld_req_valid = 1'b1;
        bus.ld_addr      = 8'h30;
        bus.ld_data      = 32'h1111_1111;
        wait_ready(1'b1);
        @(negedge clk);                         // WR
        check("rstwr_oe_in_wr", 64'(bus.mem_wdata_oe), 64'(1));
        rst_n = 1'b0;                           // ld_req_valid stays high
        @(negedge clk);
        #1;
        check("rstwr_oe",       64'(bus.mem_wdata_oe), 64'(0));
        check("rstwr_fetch_en", 64'(bus.mem_fetch_en), 64'(1));
        check("rstwr_ack",      64'(bus.ld_ack),       64'(0));
        check("rstwr_ready",    64'(bus.ld_req_ready), 64'(0));
        bus.ld_req_valid = 1'b0;
        rst_n            = 1'b1;
        @(negedge clk);
        check("rstwr_ack_late", 64'(bus.ld_ack),   64'(0));
        check("rstwr_count",    64'(bus.ld_count), 64'(0));
        do_read(8'h10, 32'h0000_000F);

        // 257 writes: counter saturates at 256; 0xFF and then 0x00 land.
        for (int i = 0; i < 257; i++) begin
            do_write(8'(i), 32'h1000_0000 + 32'(i));
            if (i == 254) check("sat_255",  64'(bus.ld_count), 64'(255));
            if (i == 255) check("sat_256",  64'(bus.ld_count), 64'(256));
        end
        check("sat_hold", 64'(bus.ld_count), 64'(256));
        do_read(8'hFF, 32'h1000_00FF);
        do_read(8'h00, 32'h1000_0100);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
